// File: rtl/classifier_topic_lookup.sv
// classifier_topic_lookup: lookup initiator for the classifier topic memories.
// Reads two hash buckets, walks their valid pointers in order (table0 slots
// then table1 slots), fetches key and expiry time per pointer and reports
// hit / miss / expired with the matching TID. One lookup in flight at a time.
// Optional build macro CLASSIFIER_TOPIC_LOOKUP_STATS_EN adds saturating
// 32-bit hit/miss/expired counters.
//
// Handshake: a request is taken on a rising clk edge where lookup_req and
// lookup_ready are both 1; lookup_req while lookup_ready=0 is dropped. Memory
// reads are single-cycle rd pulses with raddr held until the matching ack;
// acks are only honoured in the state that waits for them.

`ifndef TOPIC_HASH_TABLE_DEPTH_NBITS
`define TOPIC_HASH_TABLE_DEPTH_NBITS 6
`endif
`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 6
`endif
`ifndef TOPIC_VALUE_NBITS
`define TOPIC_VALUE_NBITS 40
`endif
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 32
`endif
`ifndef EXP_TIME_NBITS
`define EXP_TIME_NBITS 16
`endif

module classifier_topic_lookup #(
    parameter int DEPTH_NBITS       = `TOPIC_HASH_TABLE_DEPTH_NBITS,
    parameter int VALUE_DEPTH_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
    parameter int VALUE_NBITS       = `TOPIC_VALUE_NBITS,
    parameter int KEY_NBITS         = `TOPIC_KEY_NBITS,
    parameter int ETIME_NBITS       = `EXP_TIME_NBITS,
    parameter int BUCKET_ENTRIES    = 4,
    parameter int BUCKET_NBITS      = BUCKET_ENTRIES*(VALUE_DEPTH_NBITS+1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lookup_req,
    input  logic [KEY_NBITS-1:0]         lookup_key,
    input  logic [DEPTH_NBITS-1:0]       lookup_hash0,
    input  logic [DEPTH_NBITS-1:0]       lookup_hash1,
    input  logic [ETIME_NBITS-1:0]       cur_time,
    output logic                         lookup_ready,
    output logic                         lookup_done,
    output logic                         lookup_hit,
    output logic                         lookup_expired,
    output logic [VALUE_DEPTH_NBITS-1:0] lookup_tid,
    output logic                         topic_hash_table0_rd,
    output logic [DEPTH_NBITS-1:0]       topic_hash_table0_raddr,
    output logic                         topic_hash_table1_rd,
    output logic [DEPTH_NBITS-1:0]       topic_hash_table1_raddr,
    input  logic                         topic_hash_table0_ack,
    input  logic [BUCKET_NBITS-1:0]      topic_hash_table0_rdata,
    input  logic                         topic_hash_table1_ack,
    input  logic [BUCKET_NBITS-1:0]      topic_hash_table1_rdata,
    output logic                         topic_key_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] topic_key_raddr,
    output logic                         topic_etime_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] topic_etime_raddr,
    input  logic                         topic_key_ack,
    input  logic [VALUE_NBITS-1:0]       topic_key_rdata,
    input  logic                         topic_etime_ack,
    input  logic [ETIME_NBITS-1:0]       topic_etime_rdata,
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
    output logic [31:0]                  stat_hit_cnt,
    output logic [31:0]                  stat_miss_cnt,
    output logic [31:0]                  stat_expired_cnt,
`endif
    output logic [2:0]                   dbg_state_o
);

    localparam int SLOT_W = VALUE_DEPTH_NBITS + 1;
    localparam int NCAND  = 2 * BUCKET_ENTRIES;
    localparam int IDX_W  = $clog2(NCAND + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BKT_WAIT = 3'd1,
        SCAN     = 3'd2,
        KEY_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [KEY_NBITS-1:0]          key_q;
    logic [DEPTH_NBITS-1:0]        hash0_q, hash1_q;
    logic [ETIME_NBITS-1:0]        time_q;
    logic [BUCKET_NBITS-1:0]       bkt0_q, bkt1_q;
    logic                          got0_q, got1_q;
    logic [KEY_NBITS-1:0]          rkey_q;
    logic [ETIME_NBITS-1:0]        retime_q;
    logic                          got_key_q, got_et_q;
    logic [IDX_W-1:0]              idx_q;
    logic [VALUE_DEPTH_NBITS-1:0]  ptr_q;
    logic                          tbl_rd_q, ent_rd_q;
    logic                          hit_q, expired_q;
    logic [VALUE_DEPTH_NBITS-1:0]  tid_q;

    logic [NCAND-1:0]                        cand_vld;
    logic [NCAND-1:0][VALUE_DEPTH_NBITS-1:0] cand_ptr;
    logic                                    found;
    logic [IDX_W-1:0]                        sel;
    logic [VALUE_DEPTH_NBITS-1:0]            sel_ptr;
    logic                                    bkt_both, ent_both;
    logic [KEY_NBITS-1:0]                    key_eff;
    logic [ETIME_NBITS-1:0]                  etime_eff;
    logic                                    key_match, not_expired;
    logic                                    unused_key_bits;

    // Only the low key bits take part in the compare.
    assign unused_key_bits = ^topic_key_rdata[VALUE_NBITS-1:KEY_NBITS];

    // Flatten both buckets into one ordered candidate list.
    always_comb begin
        cand_vld = '0;
        cand_ptr = '0;
        for (int i = 0; i < BUCKET_ENTRIES; i++) begin
            cand_vld[i]                  = bkt0_q[i*SLOT_W + VALUE_DEPTH_NBITS];
            cand_ptr[i]                  = bkt0_q[i*SLOT_W +: VALUE_DEPTH_NBITS];
            cand_vld[i + BUCKET_ENTRIES] = bkt1_q[i*SLOT_W + VALUE_DEPTH_NBITS];
            cand_ptr[i + BUCKET_ENTRIES] = bkt1_q[i*SLOT_W +: VALUE_DEPTH_NBITS];
        end
    end

    // Priority encoder: first valid candidate at or above the scan index.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_ptr = '0;
        for (int i = NCAND - 1; i >= 0; i--) begin
            if (cand_vld[i] && (IDX_W'(i) >= idx_q)) begin
                found   = 1'b1;
                sel     = IDX_W'(i);
                sel_ptr = cand_ptr[i];
            end
        end
    end

    // Response-complete detection and compare; a same-cycle ack is used directly.
    always_comb begin
        bkt_both    = (got0_q | topic_hash_table0_ack) & (got1_q | topic_hash_table1_ack);
        ent_both    = (got_key_q | topic_key_ack) & (got_et_q | topic_etime_ack);
        key_eff     = topic_key_ack ? topic_key_rdata[KEY_NBITS-1:0] : rkey_q;
        etime_eff   = topic_etime_ack ? topic_etime_rdata : retime_q;
        key_match   = (key_eff == key_q);
        not_expired = (etime_eff > time_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (lookup_req) state_d = BKT_WAIT;
            BKT_WAIT: if (bkt_both)   state_d = SCAN;
            SCAN:     state_d = found ? KEY_WAIT : DONE;
            KEY_WAIT: if (ent_both)   state_d = key_match ? DONE : SCAN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        lookup_ready = (state_q == IDLE);
        lookup_done  = (state_q == DONE);
        dbg_state_o  = state_q;
    end

    assign lookup_hit              = hit_q;
    assign lookup_expired          = expired_q;
    assign lookup_tid              = tid_q;
    assign topic_hash_table0_rd    = tbl_rd_q;
    assign topic_hash_table1_rd    = tbl_rd_q;
    assign topic_hash_table0_raddr = hash0_q;
    assign topic_hash_table1_raddr = hash1_q;
    assign topic_key_rd            = ent_rd_q;
    assign topic_etime_rd          = ent_rd_q;
    assign topic_key_raddr         = ptr_q;
    assign topic_etime_raddr       = ptr_q;

    // Datapath: request latch, bucket/entry capture, scan index, read pulses, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            hash0_q   <= '0;
            hash1_q   <= '0;
            time_q    <= '0;
            bkt0_q    <= '0;
            bkt1_q    <= '0;
            got0_q    <= 1'b0;
            got1_q    <= 1'b0;
            rkey_q    <= '0;
            retime_q  <= '0;
            got_key_q <= 1'b0;
            got_et_q  <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            tbl_rd_q  <= 1'b0;
            ent_rd_q  <= 1'b0;
            hit_q     <= 1'b0;
            expired_q <= 1'b0;
            tid_q     <= '0;
        end else begin
            tbl_rd_q <= (state_q == IDLE) && lookup_req;
            ent_rd_q <= (state_q == SCAN) && found;
            case (state_q)
                IDLE: if (lookup_req) begin
                    key_q   <= lookup_key;
                    hash0_q <= lookup_hash0;
                    hash1_q <= lookup_hash1;
                    time_q  <= cur_time;
                    got0_q  <= 1'b0;
                    got1_q  <= 1'b0;
                end
                BKT_WAIT: begin
                    if (topic_hash_table0_ack) begin
                        bkt0_q <= topic_hash_table0_rdata;
                        got0_q <= 1'b1;
                    end
                    if (topic_hash_table1_ack) begin
                        bkt1_q <= topic_hash_table1_rdata;
                        got1_q <= 1'b1;
                    end
                    if (bkt_both) idx_q <= '0;
                end
                SCAN: if (found) begin
                    ptr_q     <= sel_ptr;
                    idx_q     <= sel + IDX_W'(1);
                    got_key_q <= 1'b0;
                    got_et_q  <= 1'b0;
                end
                KEY_WAIT: begin
                    if (topic_key_ack) begin
                        rkey_q    <= topic_key_rdata[KEY_NBITS-1:0];
                        got_key_q <= 1'b1;
                    end
                    if (topic_etime_ack) begin
                        retime_q <= topic_etime_rdata;
                        got_et_q <= 1'b1;
                    end
                    if (ent_both && key_match) begin
                        hit_q     <= not_expired;
                        expired_q <= ~not_expired;
                        tid_q     <= ptr_q;
                    end
                end
                DONE: begin
                    hit_q     <= 1'b0;
                    expired_q <= 1'b0;
                    tid_q     <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, exp_cnt_q;

    // Saturating result counters, bumped on the done strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            exp_cnt_q  <= '0;
        end else if (state_q == DONE) begin
            if (hit_q && (hit_cnt_q != '1))                 hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (expired_q && (exp_cnt_q != '1))             exp_cnt_q  <= exp_cnt_q + 32'd1;
            if (!hit_q && !expired_q && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign stat_hit_cnt     = hit_cnt_q;
    assign stat_miss_cnt    = miss_cnt_q;
    assign stat_expired_cnt = exp_cnt_q;
`endif

endmodule
